// File: rtl/vga_bus_arbiter.sv
// Two-requester arbiter and ISA-style bus cycle sequencer for the VGA card.
// Grants one requester at a time and runs setup/strobe/wait/hold with all bus pins registered.
module vga_bus_arbiter #(
    parameter int SETUP_CLKS   = 2,
    parameter int STROBE_CLKS  = 4,
    parameter int HOLD_CLKS    = 2,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic        mclk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [1:0]  is_io,
    input  logic [1:0]  rw,
    input  logic [1:0]  sa0_in,
    input  logic [1:0]  sa12_in,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic [1:0]  ack,
    output logic        err,
    output logic [15:0] rdata,
    input  logic        WAIT,
    input  logic [15:0] DG_in,
    output logic [15:0] DG_out,
    output logic        DG_oe,
    output logic        BALE,
    output logic        MEMR,
    output logic        MEMW,
    output logic        IOR,
    output logic        IOW,
    output logic        SA0,
    output logic        SA12,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_STROBE, S_WAITRDY, S_HOLD, S_DONE, S_RECOVER
    } state_t;

    localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CLKS - 1);
    localparam logic [7:0] STROBE_LAST = 8'(STROBE_CLKS - 1);
    localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CLKS - 1);
    localparam logic [7:0] WAIT_LAST   = 8'(WAIT_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic        io_q, io_d;
    logic        rw_q, rw_d;
    logic        err_pending_q, err_pending_d;
    logic [1:0]  ack_q, ack_d;
    logic        err_q, err_d;
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] dg_out_q, dg_out_d;
    logic        dg_oe_q, dg_oe_d;
    logic        bale_q, bale_d;
    logic        sa0_q, sa0_d;
    logic        sa12_q, sa12_d;
    // Active-low strobes packed as {MEMR, MEMW, IOR, IOW}
    logic [3:0]  strb_n_q, strb_n_d;
    logic        win;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        io_d          = io_q;
        rw_d          = rw_q;
        err_pending_d = err_pending_q;
        ack_d         = 2'b00;
        err_d         = 1'b0;
        rdata_d       = rdata_q;
        dg_out_d      = dg_out_q;
        dg_oe_d       = dg_oe_q;
        bale_d        = bale_q;
        sa0_d         = sa0_q;
        sa12_d        = sa12_q;
        strb_n_d      = strb_n_q;
        win           = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    // A lone requester wins outright; a tie goes to the one not served last
                    win          = (req == 2'b11) ? ~last_grant_q : req[1];
                    grant_d      = win;
                    last_grant_d = win;
                    io_d         = is_io[win];
                    rw_d         = rw[win];
                    sa0_d        = sa0_in[win];
                    sa12_d       = sa12_in[win];
                    bale_d       = 1'b0;
                    if (!rw[win]) begin
                        dg_oe_d  = 1'b1;
                        dg_out_d = win ? wdata1 : wdata0;
                    end
                    cnt_d   = 8'd0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = S_STROBE;
                    case ({io_q, rw_q})
                        2'b01:   strb_n_d = 4'b0111;
                        2'b00:   strb_n_d = 4'b1011;
                        2'b11:   strb_n_d = 4'b1101;
                        default: strb_n_d = 4'b1110;
                    endcase
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_STROBE: begin
                if (cnt_q == STROBE_LAST) begin
                    cnt_d = 8'd0;
                    if (!io_q && !WAIT) begin
                        state_d = S_WAITRDY;
                    end else begin
                        if (rw_q) rdata_d = DG_in;
                        strb_n_d = 4'hF;
                        state_d  = S_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WAITRDY: begin
                if (WAIT) begin
                    if (rw_q) rdata_d = DG_in;
                    strb_n_d = 4'hF;
                    cnt_d    = 8'd0;
                    state_d  = S_HOLD;
                end else if (cnt_q == WAIT_LAST) begin
                    err_pending_d = 1'b1;
                    rdata_d       = 16'hFFFF;
                    strb_n_d      = 4'hF;
                    cnt_d         = 8'd0;
                    state_d       = S_HOLD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    ack_d[grant_q] = 1'b1;
                    err_d          = err_pending_q;
                    bale_d         = 1'b1;
                    sa0_d          = 1'b1;
                    sa12_d         = 1'b1;
                    dg_oe_d        = 1'b0;
                    dg_out_d       = 16'h0001;
                    cnt_d          = 8'd0;
                    state_d        = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_RECOVER;
            end
            S_RECOVER: begin
                err_pending_d = 1'b0;
                state_d       = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge mclk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= 8'd0;
            grant_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            io_q          <= 1'b0;
            rw_q          <= 1'b0;
            err_pending_q <= 1'b0;
            ack_q         <= 2'b00;
            err_q         <= 1'b0;
            rdata_q       <= 16'h0000;
            dg_out_q      <= 16'h0001;
            dg_oe_q       <= 1'b0;
            bale_q        <= 1'b1;
            sa0_q         <= 1'b1;
            sa12_q        <= 1'b1;
            strb_n_q      <= 4'hF;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            io_q          <= io_d;
            rw_q          <= rw_d;
            err_pending_q <= err_pending_d;
            ack_q         <= ack_d;
            err_q         <= err_d;
            rdata_q       <= rdata_d;
            dg_out_q      <= dg_out_d;
            dg_oe_q       <= dg_oe_d;
            bale_q        <= bale_d;
            sa0_q         <= sa0_d;
            sa12_q        <= sa12_d;
            strb_n_q      <= strb_n_d;
        end
    end

    assign ack    = ack_q;
    assign err    = err_q;
    assign rdata  = rdata_q;
    assign DG_out = dg_out_q;
    assign DG_oe  = dg_oe_q;
    assign BALE   = bale_q;
    assign SA0    = sa0_q;
    assign SA12   = sa12_q;
    assign MEMR   = strb_n_q[3];
    assign MEMW   = strb_n_q[2];
    assign IOR    = strb_n_q[1];
    assign IOW    = strb_n_q[0];
    assign busy   = (state_q != S_IDLE);

endmodule
